// File: rtl/trap_controller.sv
// Trap arbiter and sequencer: picks one exception or interrupt by fixed
// priority, flushes the pipeline, waits for the ROB to drain, then presents
// the trap to the CSR/redirect logic over a valid/ready handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | arbitrating; mret honoured here only
// FLUSH   | one-cycle flush pulse being driven
// DRAIN   | waiting for rob_empty
// PRESENT | trap_valid high, waiting for trap_ready
module trap_controller #(
    parameter int NUM_EXC    = 8,
    parameter int NUM_IRQ    = 4,
    parameter int CODE_WIDTH = 5,
    parameter int XLEN       = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_EXC-1:0]    exc_req,
    input  logic [NUM_IRQ-1:0]    irq_pending,
    input  logic [NUM_IRQ-1:0]    irq_enable,
    input  logic                  global_ie,
    input  logic [XLEN-1:0]       epc_in,
    input  logic                  rob_empty,
    input  logic                  mret,
    input  logic                  trap_ready,
    output logic                  flush,
    output logic                  trap_valid,
    output logic [CODE_WIDTH-1:0] trap_code,
    output logic                  trap_is_irq,
    output logic [XLEN-1:0]       trap_epc,
    output logic                  in_handler,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  trap_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FLUSH   = 2'd1,
        S_DRAIN   = 2'd2,
        S_PRESENT = 2'd3
    } state_t;

    state_t                state;
    logic [NUM_IRQ-1:0]    irq_qual;
    logic                  exc_any;
    logic                  irq_any;
    logic [CODE_WIDTH-1:0] exc_idx;
    logic [CODE_WIDTH-1:0] irq_idx;

    // Interrupts are masked globally and while a handler is resident; the
    // registered in_handler is used, so an mret in the same cycle does not
    // unmask until the following evaluation.
    assign irq_qual = irq_pending & irq_enable & {NUM_IRQ{global_ie & ~in_handler}};
    assign exc_any  = |exc_req;
    assign irq_any  = |irq_qual;

    // Lowest-index priority encoders; scanning downward lets the lowest set bit win.
    always_comb begin
        exc_idx = '0;
        for (int i = NUM_EXC - 1; i >= 0; i--) begin
            if (exc_req[i]) exc_idx = CODE_WIDTH'(i);
        end
        irq_idx = '0;
        for (int j = NUM_IRQ - 1; j >= 0; j--) begin
            if (irq_qual[j]) irq_idx = CODE_WIDTH'(j);
        end
    end

    // Trap sequencing FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            flush       <= 1'b0;
            trap_valid  <= 1'b0;
            trap_code   <= '0;
            trap_is_irq <= 1'b0;
            trap_epc    <= '0;
            in_handler  <= 1'b0;
            busy        <= 1'b0;
            trap_count  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mret) in_handler <= 1'b0;
                    if (exc_any) begin
                        trap_code   <= exc_idx;
                        trap_is_irq <= 1'b0;
                        trap_epc    <= epc_in;
                        flush       <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_FLUSH;
                    end else if (irq_any) begin
                        trap_code   <= irq_idx;
                        trap_is_irq <= 1'b1;
                        trap_epc    <= epc_in;
                        flush       <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    flush <= 1'b0;
                    state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (rob_empty) begin
                        trap_valid <= 1'b1;
                        state      <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (trap_ready) begin
                        trap_valid <= 1'b0;
                        busy       <= 1'b0;
                        in_handler <= 1'b1;
                        trap_count <= trap_count + CNT_WIDTH'(1);
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    flush      <= 1'b0;
                    trap_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed scenarios with literal
// expectations plus a randomized run checked against a transaction-level model.
module tb_trap_controller;

    localparam int NUM_EXC    = 8;
    localparam int NUM_IRQ    = 4;
    localparam int CODE_WIDTH = 5;
    localparam int XLEN       = 32;
    localparam int CNT_WIDTH  = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_EXC-1:0]    exc_req = '0;
    logic [NUM_IRQ-1:0]    irq_pending = '0;
    logic [NUM_IRQ-1:0]    irq_enable = '0;
    logic                  global_ie = 1'b0;
    logic [XLEN-1:0]       epc_in = '0;
    logic                  rob_empty = 1'b0;
    logic                  mret = 1'b0;
    logic                  trap_ready = 1'b0;
    logic                  flush;
    logic                  trap_valid;
    logic [CODE_WIDTH-1:0] trap_code;
    logic                  trap_is_irq;
    logic [XLEN-1:0]       trap_epc;
    logic                  in_handler;
    logic                  busy;
    logic [CNT_WIDTH-1:0]  trap_count;

    int checks = 0;
    int errors = 0;

    trap_controller #(
        .NUM_EXC(NUM_EXC), .NUM_IRQ(NUM_IRQ), .CODE_WIDTH(CODE_WIDTH),
        .XLEN(XLEN), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .exc_req(exc_req), .irq_pending(irq_pending),
        .irq_enable(irq_enable), .global_ie(global_ie), .epc_in(epc_in),
        .rob_empty(rob_empty), .mret(mret), .trap_ready(trap_ready),
        .flush(flush), .trap_valid(trap_valid), .trap_code(trap_code),
        .trap_is_irq(trap_is_irq), .trap_epc(trap_epc), .in_handler(in_handler),
        .busy(busy), .trap_count(trap_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Transaction-level model: a trap is either absent or in flight; an
    // in-flight trap has an age in cycles and becomes presented once it is
    // at least two cycles old and the ROB is seen empty.
    bit          m_active = 0;
    bit          m_presented = 0;
    int          m_age = 0;
    int          m_code = 0;
    bit          m_irq = 0;
    logic [31:0] m_epc = '0;
    bit          m_ih = 0;
    int          m_count = 0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_active = 0; m_presented = 0; m_age = 0; m_ih = 0; m_count = 0;
        end else if (!m_active) begin
            bit old_ih;
            old_ih = m_ih;
            if (mret) m_ih = 0;
            if (exc_req != 0) begin
                m_active = 1; m_age = 1; m_irq = 0;
                m_code = lowest(16'(exc_req)); m_epc = epc_in;
            end else if (global_ie && !old_ih && (irq_pending & irq_enable) != 0) begin
                m_active = 1; m_age = 1; m_irq = 1;
                m_code = lowest(16'(irq_pending & irq_enable)); m_epc = epc_in;
            end
        end else if (m_presented) begin
            if (trap_ready) begin
                m_active = 0; m_presented = 0; m_ih = 1;
                m_count = (m_count + 1) % (1 << CNT_WIDTH);
            end
        end else begin
            if (m_age >= 2 && rob_empty) m_presented = 1;
            m_age++;
        end
    end

    // Compare every cycle on the falling edge.
    initial forever begin
        @(negedge clk);
        chk("flush", 64'(flush), 64'(m_active && !m_presented && m_age == 1));
        chk("busy", 64'(busy), 64'(m_active));
        chk("trap_valid", 64'(trap_valid), 64'(m_presented));
        chk("in_handler", 64'(in_handler), 64'(m_ih));
        chk("trap_count", 64'(trap_count), 64'(m_count));
        if (m_presented) begin
            chk("trap_code", 64'(trap_code), 64'(m_code));
            chk("trap_is_irq", 64'(trap_is_irq), 64'(m_irq));
            chk("trap_epc", 64'(trap_epc), 64'(m_epc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int first_valid;
    int nflush;
    logic [1:0] wrap_tbl [4];

    initial begin
        wrap_tbl[0] = 2'd2; wrap_tbl[1] = 2'd3; wrap_tbl[2] = 2'd0; wrap_tbl[3] = 2'd1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_valid", 64'(trap_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_count", 64'(trap_count), 64'd0);
        chk("rst_epc", 64'(trap_epc), 64'd0);
        rst = 1'b0;

        // Exception beats interrupt; minimum latency.
        exc_req = 8'h24; irq_pending = 4'h1; irq_enable = 4'h1; global_ie = 1'b1;
        rob_empty = 1'b1; trap_ready = 1'b1; epc_in = 32'h1000_0040;
        tick();
        chk("t1_flush", 64'(flush), 64'd1);
        exc_req = '0; epc_in = 32'h0000_dead;
        tick();
        chk("t1_flush_drop", 64'(flush), 64'd0);
        chk("t1_not_yet", 64'(trap_valid), 64'd0);
        tick();
        chk("t1_valid", 64'(trap_valid), 64'd1);
        chk("t1_code", 64'(trap_code), 64'd2);
        chk("t1_isirq", 64'(trap_is_irq), 64'd0);
        chk("t1_epc", 64'(trap_epc), 64'h1000_0040);
        tick();
        chk("t1_count", 64'(trap_count), 64'd1);
        chk("t1_ih", 64'(in_handler), 64'd1);

        // Interrupt qualification and mret timing.
        irq_pending = 4'h6; irq_enable = 4'h4; mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("t2_mret_noc", 64'(busy), 64'd0);
        chk("t2_ih_clr", 64'(in_handler), 64'd0);
        tick();
        chk("t2_cap", 64'(busy), 64'd1);
        tick(); tick();
        chk("t2_code", 64'(trap_code), 64'd2);
        chk("t2_isirq", 64'(trap_is_irq), 64'd1);
        tick();
        repeat (3) tick();
        chk("t2_masked", 64'(busy), 64'd0);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("t2_same_cyc", 64'(busy), 64'd0);
        tick();
        chk("t2_after_mret", 64'(busy), 64'd1);
        irq_pending = '0;
        repeat (3) tick();
        chk("t2_count", 64'(trap_count), 64'd3);

        // Slow drain, slow accept, mret in DRAIN, exception during PRESENT.
        exc_req = 8'h10; rob_empty = 1'b0; trap_ready = 1'b0; epc_in = 32'h2000_0000;
        first_valid = 0; nflush = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (trap_valid && first_valid == 0) first_valid = t;
            if (flush && t <= 11) nflush++;
            if (t == 1) begin exc_req = '0; epc_in = $urandom; end
            if (t == 3) mret = 1'b1;
            if (t == 4) begin mret = 1'b0; chk("t3_mret_ign", 64'(in_handler), 64'd1); end
            if (t == 7) rob_empty = 1'b1;
            if (t == 9) begin exc_req = 8'h01; chk("t3_epc_hold", 64'(trap_epc), 64'h2000_0000); end
            if (t == 10) trap_ready = 1'b1;
            if (t == 11) chk("t3_count", 64'(trap_count), 64'd0);
        end
        chk("t3_first_valid", 64'(first_valid), 64'd8);
        chk("t3_one_flush", 64'(nflush), 64'd1);
        chk("t3_next_cap", 64'(busy), 64'd1);
        exc_req = '0;
        tick(); tick();
        chk("t3_code2", 64'(trap_code), 64'd0);
        tick();

        // Reset mid-DRAIN, then held exception restarts; counter wraps.
        exc_req = 8'h08; rob_empty = 1'b0;
        repeat (3) tick();
        #1 rst = 1'b1;
        #1;
        chk("t4_rst_busy", 64'(busy), 64'd0);
        chk("t4_rst_flush", 64'(flush), 64'd0);
        chk("t4_rst_ih", 64'(in_handler), 64'd0);
        chk("t4_rst_count", 64'(trap_count), 64'd0);
        rst = 1'b0;
        tick();
        chk("t4_restart", 64'(flush), 64'd1);
        exc_req = '0; rob_empty = 1'b1; trap_ready = 1'b1;
        tick(); tick();
        chk("t4_code", 64'(trap_code), 64'd3);
        tick();
        chk("t4_count1", 64'(trap_count), 64'd1);
        for (int i = 0; i < 4; i++) begin
            exc_req = 8'(1 << (i + 1));
            tick();
            exc_req = '0;
            repeat (3) tick();
            chk("t5_wrap", 64'(trap_count), 64'(wrap_tbl[i]));
        end

        // Randomized run against the model.
        for (int c = 0; c < 3000; c++) begin
            exc_req     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : '0;
            irq_pending = 4'($urandom);
            irq_enable  = 4'($urandom);
            global_ie   = ($urandom_range(0, 3) != 0);
            epc_in      = $urandom;
            rob_empty   = ($urandom_range(0, 9) < 7);
            trap_ready  = ($urandom_range(0, 9) < 6);
            mret        = ($urandom_range(0, 6) == 0);
            tick();
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
